// File: rtl/grid_draw_sequencer_pkg.sv
// Shared definitions for the grid draw sequencer: board geometry, drawer
// pipeline depth and the sequencer state encoding.
package grid_draw_sequencer_pkg;

    localparam int GRID_COLS         = 8;
    localparam int GRID_ROWS         = 6;
    localparam int CELL_PX           = 20;
    localparam int DRAWER_PIPE_DEPTH = 3;
    localparam int PLOT_SKIP         = DRAWER_PIPE_DEPTH;
    localparam int TIMEOUT           = 2047;

    localparam int CELL_W = 4;
    localparam int WAIT_W = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_DRAW,
        S_NEXT,
        S_FINISH
    } seq_state_t;

endpackage

// File: rtl/grid_cell_stepper.sv
// Cell position register for the sequencer: direct load, raster step with
// column wrap, and a flag marking the bottom-right cell of the board.
module grid_cell_stepper #(
    parameter int GRID_COLS = grid_draw_sequencer_pkg::GRID_COLS,
    parameter int GRID_ROWS = grid_draw_sequencer_pkg::GRID_ROWS
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic [3:0] load_x,
    input  logic [3:0] load_y,
    input  logic       step,
    output logic [3:0] cell_x,
    output logic [3:0] cell_y,
    output logic       last_cell
);
    import grid_draw_sequencer_pkg::*;

    localparam logic [CELL_W-1:0] LAST_X = CELL_W'(GRID_COLS - 1);
    localparam logic [CELL_W-1:0] LAST_Y = CELL_W'(GRID_ROWS - 1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cell_x <= '0;
            cell_y <= '0;
        end else if (load) begin
            cell_x <= load_x;
            cell_y <= load_y;
        end else if (step) begin
            if (cell_x == LAST_X) begin
                cell_x <= '0;
                cell_y <= cell_y + 1'b1;
            end else begin
                cell_x <= cell_x + 1'b1;
            end
        end
    end

    assign last_cell = (cell_x == LAST_X) && (cell_y == LAST_Y);

endmodule

// File: rtl/grid_draw_sequencer.sv
// Upstream controller for the 20x20 square drawer: walks the board cell by
// cell, pulses the drawer's reset between cells and gates its VGA plot strobe.
module grid_draw_sequencer #(
    parameter int GRID_COLS = grid_draw_sequencer_pkg::GRID_COLS,
    parameter int GRID_ROWS = grid_draw_sequencer_pkg::GRID_ROWS,
    parameter int PLOT_SKIP = grid_draw_sequencer_pkg::PLOT_SKIP,
    parameter int TIMEOUT   = grid_draw_sequencer_pkg::TIMEOUT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       full_redraw,
    input  logic [3:0] sel_x,
    input  logic [3:0] sel_y,
    input  logic       sq_done,
    output logic [3:0] cell_x,
    output logic [3:0] cell_y,
    output logic       sq_run,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       err
);
    import grid_draw_sequencer_pkg::*;

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic              single_mode;
    logic              err_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              sel_oob;
    logic              cell_load;
    logic              cell_step;
    logic              last_cell;
    logic [CELL_W-1:0] load_x;
    logic [CELL_W-1:0] load_y;
    logic              timeout_hit;

    assign sel_oob     = (int'(sel_x) >= GRID_COLS) || (int'(sel_y) >= GRID_ROWS);
    assign load_x      = full_redraw ? '0 : sel_x;
    assign load_y      = full_redraw ? '0 : sel_y;
    assign timeout_hit = (state == S_DRAW) && !sq_done && (wait_cnt == WAIT_W'(TIMEOUT - 1));

    grid_cell_stepper #(
        .GRID_COLS (GRID_COLS),
        .GRID_ROWS (GRID_ROWS)
    ) u_stepper (
        .clk       (clk),
        .resetn    (resetn),
        .load      (cell_load),
        .load_x    (load_x),
        .load_y    (load_y),
        .step      (cell_step),
        .cell_x    (cell_x),
        .cell_y    (cell_y),
        .last_cell (last_cell)
    );

    // sq_done is only meaningful in DRAW; a stale flag elsewhere is ignored.
    always_comb begin
        state_nxt = state;
        cell_load = 1'b0;
        cell_step = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    cell_load = 1'b1;
                    state_nxt = (!full_redraw && sel_oob) ? S_FINISH : S_LAUNCH;
                end
            end
            S_LAUNCH: state_nxt = S_DRAW;
            S_DRAW: begin
                if (sq_done) begin
                    state_nxt = S_NEXT;
                end else if (timeout_hit) begin
                    state_nxt = S_FINISH;
                end
            end
            S_NEXT: begin
                if (single_mode || last_cell) begin
                    state_nxt = S_FINISH;
                end else begin
                    cell_step = 1'b1;
                    state_nxt = S_LAUNCH;
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            single_mode <= 1'b0;
            err_q       <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                single_mode <= !full_redraw;
                err_q       <= 1'b0;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
            if (state == S_LAUNCH) begin
                wait_cnt <= '0;
            end else if (state == S_DRAW && wait_cnt != WAIT_W'(TIMEOUT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // The first PLOT_SKIP draw cycles carry no valid pixel from the drawer ROM.
    assign sq_run = (state == S_DRAW);
    assign plot   = (state == S_DRAW) && (wait_cnt >= WAIT_W'(PLOT_SKIP));
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_FINISH);
    assign err    = err_q;

endmodule

// File: tb/tb_grid_draw_sequencer.sv
// Self-checking bench for grid_draw_sequencer: a randomized drawer model feeds
// sq_done while a cell-level reference model predicts cells, timing and flags.
module tb_grid_draw_sequencer;

    localparam int GRID_COLS  = 8;
    localparam int GRID_ROWS  = 6;
    localparam int PLOT_SKIP  = 3;
    localparam int TIMEOUT    = 2047;
    localparam int MAX_CYCLES = 6000;
    localparam int NEVER      = 100000;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       full_redraw;
    logic [3:0] sel_x;
    logic [3:0] sel_y;
    logic       sq_done;
    logic [3:0] cell_x;
    logic [3:0] cell_y;
    logic       sq_run;
    logic       plot;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    grid_draw_sequencer dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .full_redraw (full_redraw),
        .sel_x       (sel_x),
        .sel_y       (sel_y),
        .sq_done     (sq_done),
        .cell_x      (cell_x),
        .cell_y      (cell_y),
        .sq_run      (sq_run),
        .plot        (plot),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Observed trace of one sequence
    logic [7:0] obs_cells[$];
    int         obs_len[$];
    int         obs_plot[$];
    int         obs_gap[$];
    int         obs_lat[$];
    int         done_cnt, done_cyc, busy_cyc, stable_bad, launch_bad;
    int         early_plot, stray_plot, end_gap;
    logic       err_at_done, err_cyc1, idle_after_done, hung;

    // Reference model output
    logic [7:0] exp_cells[$];
    int         exp_len[$];
    int         exp_busy;
    logic       exp_err;

    // Cell-level model: which cells get drawn, how long each draw lasts given
    // the drawer latency the bench chose, and total busy time including FINISH.
    function automatic void model_expect(input logic full, input logic [3:0] sx, input logic [3:0] sy);
        exp_cells.delete();
        exp_len.delete();
        exp_busy = 1;
        exp_err  = 1'b0;
        if (full) begin
            for (int y = 0; y < GRID_ROWS; y++)
                for (int x = 0; x < GRID_COLS; x++)
                    exp_cells.push_back({4'(y), 4'(x)});
        end else if (int'(sx) < GRID_COLS && int'(sy) < GRID_ROWS) begin
            exp_cells.push_back({sy, sx});
        end
        for (int i = 0; i < exp_cells.size(); i++) begin
            int lat;
            int len;
            lat = (i < obs_lat.size()) ? obs_lat[i] : 1;
            len = (lat > TIMEOUT) ? TIMEOUT : lat;
            exp_len.push_back(len);
            exp_busy += 1 + len;
            if (lat > TIMEOUT) begin
                exp_err = 1'b1;
                while (exp_cells.size() > i + 1) exp_cells.pop_back();
                break;
            end
            exp_busy += 1;
        end
    endfunction

    // Drives one start, then plays the drawer (sq_done after a random latency
    // per cell) while recording the trace; never compares anything itself.
    task automatic run_seq(input logic full, input logic [3:0] sx, input logic [3:0] sy,
                           input int lat_lo, input int lat_hi, input logic stale,
                           input int second_start_at);
        logic       prev_run  = 1'b0;
        logic       prev_busy = 1'b0;
        logic [7:0] prev_cell = 8'h00;
        logic [7:0] run_cell  = 8'h00;
        logic       prev_done = 1'b0;
        int         run_len   = 0;
        int         plot_run  = 0;
        int         gap       = 0;
        int         cur_lat   = 0;
        obs_cells.delete(); obs_len.delete(); obs_plot.delete();
        obs_gap.delete();   obs_lat.delete();
        done_cnt = 0; done_cyc = -1; busy_cyc = 0; stable_bad = 0; launch_bad = 0;
        early_plot = 0; stray_plot = 0; end_gap = -1;
        err_at_done = 1'bx; err_cyc1 = 1'bx; idle_after_done = 1'b0; hung = 1'b1;
        @(negedge clk);
        start = 1'b1; full_redraw = full; sel_x = sx; sel_y = sy; sq_done = stale;
        for (int cyc = 1; cyc <= MAX_CYCLES; cyc++) begin
            @(negedge clk);
            start       = (cyc == second_start_at);
            full_redraw = 1'($urandom);
            sel_x       = 4'($urandom);
            sel_y       = 4'($urandom);
            if (cyc == 1) err_cyc1 = err;
            if (busy) busy_cyc++;
            if (prev_done) idle_after_done = !busy;
            if (done) begin
                done_cnt++;
                done_cyc    = cyc;
                err_at_done = err;
                end_gap     = gap;
            end
            if (sq_run) begin
                if (!prev_run) begin
                    cur_lat = int'($urandom_range(lat_hi, lat_lo));
                    obs_lat.push_back(cur_lat);
                    obs_cells.push_back({cell_y, cell_x});
                    obs_gap.push_back(gap);
                    if (!prev_busy || prev_cell != {cell_y, cell_x}) launch_bad++;
                    run_cell = {cell_y, cell_x};
                    run_len  = 0;
                    plot_run = 0;
                    gap      = 0;
                end else if ({cell_y, cell_x} != run_cell) begin
                    stable_bad++;
                end
                if (plot) begin
                    plot_run++;
                    if (run_len < PLOT_SKIP) early_plot++;
                end
                sq_done = (run_len == cur_lat - 1);
                run_len++;
            end else begin
                if (prev_run) begin
                    obs_len.push_back(run_len);
                    obs_plot.push_back(plot_run);
                end
                if (plot) stray_plot++;
                if (busy && !done) gap++;
                sq_done = stale;
            end
            prev_run = sq_run; prev_busy = busy; prev_done = done; prev_cell = {cell_y, cell_x};
            if (!busy) begin
                hung = 1'b0;
                break;
            end
        end
        start   = 1'b0;
        sq_done = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({cell_y, cell_x} !== 8'h00) begin n_errors++; $display("[TB] FAIL reset_cell: got %h expected 00", {cell_y, cell_x}); end
        n_checks++; if (sq_run !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_sq_run: got %b expected 0", sq_run); end
        n_checks++; if (plot !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_plot: got %b expected 0", plot); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        resetn = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL idle_after_reset: busy got %b expected 0", busy); end
    endtask

    task automatic test_single_redraw();
        run_seq(1'b0, 4'd3, 4'd2, 1202, 1202, 1'b0, 0);
        model_expect(1'b0, 4'd3, 4'd2);
        n_checks++; if (hung !== 1'b0) begin n_errors++; $display("[TB] FAIL single_hung: busy never dropped within %0d cycles", MAX_CYCLES); end
        n_checks++; if (obs_cells.size() !== exp_cells.size()) begin n_errors++; $display("[TB] FAIL single_count: got %0d cells expected %0d", obs_cells.size(), exp_cells.size()); end
        n_checks++; if (obs_cells.size() < 1 || obs_cells[0] !== exp_cells[0]) begin n_errors++; $display("[TB] FAIL single_cell: got %0d cells, expected cell %h", obs_cells.size(), exp_cells[0]); end
        n_checks++; if (obs_len.size() < 1 || obs_len[0] !== exp_len[0]) begin n_errors++; $display("[TB] FAIL single_draw_len: got %0d entries expected length %0d", obs_len.size(), exp_len[0]); end
        n_checks++; if (obs_plot.size() < 1 || obs_plot[0] !== exp_len[0] - PLOT_SKIP) begin n_errors++; $display("[TB] FAIL single_plot_count: expected %0d plot cycles", exp_len[0] - PLOT_SKIP); end
        n_checks++; if (obs_gap.size() < 1 || obs_gap[0] !== 1) begin n_errors++; $display("[TB] FAIL single_launch: expected exactly 1 launch cycle before draw"); end
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("[TB] FAIL single_done_count: got %0d expected 1", done_cnt); end
        n_checks++; if (done_cyc !== exp_busy) begin n_errors++; $display("[TB] FAIL single_done_cycle: got %0d expected %0d", done_cyc, exp_busy); end
        n_checks++; if (busy_cyc !== exp_busy) begin n_errors++; $display("[TB] FAIL single_busy_cycles: got %0d expected %0d", busy_cyc, exp_busy); end
        n_checks++; if (idle_after_done !== 1'b1) begin n_errors++; $display("[TB] FAIL single_busy_drop: got %b expected 1", idle_after_done); end
        n_checks++; if (err_at_done !== 1'b0) begin n_errors++; $display("[TB] FAIL single_err: got %b expected 0", err_at_done); end
        n_checks++; if (stable_bad + launch_bad !== 0) begin n_errors++; $display("[TB] FAIL single_cell_stable: got %0d changes expected 0", stable_bad + launch_bad); end
        n_checks++; if (early_plot + stray_plot !== 0) begin n_errors++; $display("[TB] FAIL single_plot_gating: got %0d bad plot cycles expected 0", early_plot + stray_plot); end
    endtask

    task automatic test_full_redraw();
        run_seq(1'b1, 4'($urandom), 4'($urandom), 1, 20, 1'b0, 0);
        model_expect(1'b1, 4'd0, 4'd0);
        n_checks++; if (hung !== 1'b0) begin n_errors++; $display("[TB] FAIL full_hung: busy never dropped within %0d cycles", MAX_CYCLES); end
        n_checks++; if (obs_cells.size() !== exp_cells.size()) begin n_errors++; $display("[TB] FAIL full_count: got %0d cells expected %0d", obs_cells.size(), exp_cells.size()); end
        for (int i = 0; i < exp_cells.size(); i++) begin
            n_checks++;
            if (i >= obs_cells.size() || obs_cells[i] !== exp_cells[i]) begin
                n_errors++; $display("[TB] FAIL full_cell[%0d]: got %h expected %h", i, (i < obs_cells.size()) ? obs_cells[i] : 8'hff, exp_cells[i]);
            end
            n_checks++;
            if (i >= obs_len.size() || obs_len[i] !== exp_len[i] || obs_gap[i] !== ((i == 0) ? 1 : 2)) begin
                n_errors++; $display("[TB] FAIL full_timing[%0d]: expected draw %0d cycles after gap %0d", i, exp_len[i], (i == 0) ? 1 : 2);
            end
            n_checks++;
            if (i >= obs_plot.size() || obs_plot[i] !== ((exp_len[i] > PLOT_SKIP) ? exp_len[i] - PLOT_SKIP : 0)) begin
                n_errors++; $display("[TB] FAIL full_plot[%0d]: got %0d expected %0d", i, (i < obs_plot.size()) ? obs_plot[i] : -1, (exp_len[i] > PLOT_SKIP) ? exp_len[i] - PLOT_SKIP : 0);
            end
        end
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("[TB] FAIL full_done_count: got %0d expected 1", done_cnt); end
        n_checks++; if (done_cyc !== exp_busy) begin n_errors++; $display("[TB] FAIL full_done_cycle: got %0d expected %0d", done_cyc, exp_busy); end
        n_checks++; if (end_gap !== 1) begin n_errors++; $display("[TB] FAIL full_last_next: got %0d cycles expected 1", end_gap); end
        n_checks++; if (err_at_done !== 1'b0) begin n_errors++; $display("[TB] FAIL full_err: got %b expected 0", err_at_done); end
        n_checks++; if (stable_bad + launch_bad !== 0) begin n_errors++; $display("[TB] FAIL full_cell_stable: got %0d changes expected 0", stable_bad + launch_bad); end
    endtask

    task automatic test_out_of_range();
        logic [3:0] xs[3];
        logic [3:0] ys[3];
        xs[0] = 4'd8; ys[0] = 4'd0;
        xs[1] = 4'd0; ys[1] = 4'd6;
        xs[2] = 4'($urandom_range(15, 8)); ys[2] = 4'($urandom_range(15, 0));
        for (int k = 0; k < 3; k++) begin
            run_seq(1'b0, xs[k], ys[k], 1, 5, 1'b0, 0);
            model_expect(1'b0, xs[k], ys[k]);
            n_checks++; if (obs_cells.size() !== 0) begin n_errors++; $display("[TB] FAIL oob_launch[%0d]: got %0d draws expected 0", k, obs_cells.size()); end
            n_checks++; if (done_cyc !== exp_busy || done_cnt !== 1) begin n_errors++; $display("[TB] FAIL oob_done[%0d]: got cycle %0d count %0d expected cycle %0d count 1", k, done_cyc, done_cnt, exp_busy); end
            n_checks++; if (busy_cyc !== exp_busy) begin n_errors++; $display("[TB] FAIL oob_busy[%0d]: got %0d expected %0d", k, busy_cyc, exp_busy); end
            n_checks++; if (err_at_done !== 1'b0) begin n_errors++; $display("[TB] FAIL oob_err[%0d]: got %b expected 0", k, err_at_done); end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] sx;
        logic [3:0] sy;
        sx = 4'($urandom_range(GRID_COLS - 1, 0));
        sy = 4'($urandom_range(GRID_ROWS - 1, 0));
        run_seq(1'b0, sx, sy, NEVER, NEVER, 1'b0, 0);
        model_expect(1'b0, sx, sy);
        n_checks++; if (obs_len.size() < 1 || obs_len[0] !== exp_len[0]) begin n_errors++; $display("[TB] FAIL timeout_len: got %0d expected %0d", (obs_len.size() > 0) ? obs_len[0] : -1, exp_len[0]); end
        n_checks++; if (err_at_done !== exp_err) begin n_errors++; $display("[TB] FAIL timeout_err: got %b expected %b", err_at_done, exp_err); end
        n_checks++; if (done_cnt !== 1 || done_cyc !== exp_busy) begin n_errors++; $display("[TB] FAIL timeout_done: got cycle %0d count %0d expected cycle %0d", done_cyc, done_cnt, exp_busy); end
        n_checks++; if (end_gap !== 0) begin n_errors++; $display("[TB] FAIL timeout_no_next: got %0d cycles expected 0", end_gap); end
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("[TB] FAIL timeout_sticky: got %b expected 1", err); end
        run_seq(1'b0, sx, sy, 4, 4, 1'b0, 0);
        n_checks++; if (err_cyc1 !== 1'b0) begin n_errors++; $display("[TB] FAIL timeout_clear: got %b expected 0", err_cyc1); end
        n_checks++; if (err_at_done !== 1'b0) begin n_errors++; $display("[TB] FAIL timeout_clear_done: got %b expected 0", err_at_done); end
    endtask

    task automatic test_start_while_busy();
        run_seq(1'b1, 4'd0, 4'd0, 1, 12, 1'b0, int'($urandom_range(150, 5)));
        model_expect(1'b1, 4'd0, 4'd0);
        n_checks++; if (obs_cells.size() !== exp_cells.size()) begin n_errors++; $display("[TB] FAIL busy_start_count: got %0d cells expected %0d", obs_cells.size(), exp_cells.size()); end
        for (int i = 0; i < exp_cells.size(); i++) begin
            n_checks++;
            if (i >= obs_cells.size() || obs_cells[i] !== exp_cells[i]) begin
                n_errors++; $display("[TB] FAIL busy_start_cell[%0d]: got %h expected %h", i, (i < obs_cells.size()) ? obs_cells[i] : 8'hff, exp_cells[i]);
            end
        end
        n_checks++; if (done_cnt !== 1 || busy_cyc !== exp_busy) begin n_errors++; $display("[TB] FAIL busy_start_done: got %0d done %0d busy expected 1 done %0d busy", done_cnt, busy_cyc, exp_busy); end
    endtask

    task automatic test_stale_done();
        logic [3:0] sx;
        logic [3:0] sy;
        sx = 4'($urandom_range(GRID_COLS - 1, 0));
        sy = 4'($urandom_range(GRID_ROWS - 1, 0));
        run_seq(1'b0, sx, sy, 5, 40, 1'b1, 0);
        model_expect(1'b0, sx, sy);
        n_checks++; if (obs_cells.size() !== 1 || obs_cells[0] !== exp_cells[0]) begin n_errors++; $display("[TB] FAIL stale_cell: got %0d draws expected 1 of cell %h", obs_cells.size(), exp_cells[0]); end
        n_checks++; if (obs_gap.size() < 1 || obs_gap[0] !== 1) begin n_errors++; $display("[TB] FAIL stale_launch: expected 1 launch cycle"); end
        n_checks++; if (obs_len.size() < 1 || obs_len[0] !== exp_len[0]) begin n_errors++; $display("[TB] FAIL stale_len: got %0d expected %0d", (obs_len.size() > 0) ? obs_len[0] : -1, exp_len[0]); end
        n_checks++; if (done_cyc !== exp_busy) begin n_errors++; $display("[TB] FAIL stale_done_cycle: got %0d expected %0d", done_cyc, exp_busy); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] sx;
        logic [3:0] sy;
        for (int k = 0; k < 8; k++) begin
            sx = 4'($urandom_range(9, 0));
            sy = 4'($urandom_range(7, 0));
            run_seq(1'b0, sx, sy, 1, 50, 1'($urandom), 0);
            model_expect(1'b0, sx, sy);
            n_checks++; if (obs_cells.size() !== exp_cells.size()) begin n_errors++; $display("[TB] FAIL b2b_count[%0d]: got %0d expected %0d", k, obs_cells.size(), exp_cells.size()); end
            n_checks++; if (exp_cells.size() > 0 && (obs_cells.size() < 1 || obs_cells[0] !== exp_cells[0] || obs_len[0] !== exp_len[0])) begin n_errors++; $display("[TB] FAIL b2b_cell[%0d]: expected cell %h for %0d cycles", k, exp_cells[0], exp_len[0]); end
            n_checks++; if (done_cnt !== 1 || done_cyc !== exp_busy) begin n_errors++; $display("[TB] FAIL b2b_done[%0d]: got cycle %0d count %0d expected cycle %0d", k, done_cyc, done_cnt, exp_busy); end
            n_checks++; if (err_at_done !== 1'b0) begin n_errors++; $display("[TB] FAIL b2b_err[%0d]: got %b expected 0", k, err_at_done); end
        end
    endtask

    task automatic test_mid_reset();
        logic hit = 1'b0;
        @(negedge clk);
        start = 1'b1; full_redraw = 1'b1; sq_done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !hit; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (sq_run && cell_x == 4'd4 && cell_y == 4'd1) hit = 1'b1;
            else sq_done = sq_run && ($urandom_range(7, 0) == 0);
        end
        n_checks++; if (hit !== 1'b1) begin n_errors++; $display("[TB] FAIL mid_reset_reach: cell (4,1) DRAW not seen within 3000 cycles"); end
        resetn = 1'b0; sq_done = 1'b0;
        @(negedge clk);
        n_checks++; if ({cell_y, cell_x, sq_run, plot, busy, done, err} !== 13'h0) begin n_errors++; $display("[TB] FAIL mid_reset_outputs: got %h expected 0", {cell_y, cell_x, sq_run, plot, busy, done, err}); end
        resetn = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("[TB] FAIL mid_reset_no_done: busy %b done %b expected 0 0", busy, done); end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; full_redraw = 1'b0;
        sel_x = 4'd0; sel_y = 4'd0; sq_done = 1'b0;
        test_reset();
        test_single_redraw();
        test_full_redraw();
        test_out_of_range();
        test_timeout();
        test_start_while_busy();
        test_stale_done();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
